// File: rtl/matrix_scroller.sv
// Column-multiplexed LED matrix driver with a frame buffer that scrolls one column
// left or right every SCROLL_FRAMES frames, fed by a valid/ready column source.
module matrix_scroller #(
   parameter int unsigned COLS          = 5,
   parameter int unsigned ROWS          = 7,
   parameter int unsigned SCAN_DIV      = 256,
   parameter int unsigned BLANK         = 2,
   parameter int unsigned SCROLL_FRAMES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            scroll_en,
   input  logic            dir,
   input  logic [ROWS-1:0] col_in,
   input  logic            col_valid,
   output logic            col_ready,
   output logic [COLS-1:0] col_sel,
   output logic [ROWS-1:0] row,
   output logic            frame_start,
   output logic            scroll_step
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned FRM_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SCROLL_FRAMES - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [COL_W-1:0] col_idx_q, col_idx_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [ROWS-1:0]  fb_q [COLS];
   logic [ROWS-1:0]  fb_d [COLS];

   logic             div_last;
   logic             frame_end;
   logic             step;
   logic             lit;
   logic [ROWS-1:0]  enter_col;

   assign div_last  = (div_cnt_q == DIV_LAST);
   assign frame_end = div_last && (col_idx_q == COL_LAST);
   assign step      = en && scroll_en && frame_end && (frame_cnt_q == FRM_LAST);
   assign lit       = en && (div_cnt_q >= BLANK_V);
   // A starved source inserts a blank column so the scroll cadence never stalls.
   assign enter_col = col_valid ? col_in : '0;

   always_comb begin
      div_cnt_d   = div_cnt_q;
      col_idx_d   = col_idx_q;
      frame_cnt_d = frame_cnt_q;
      fb_d        = fb_q;
      if (en) begin
         div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
         if (div_last) begin
            col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
         end
         if (frame_end) begin
            frame_cnt_d = (frame_cnt_q == FRM_LAST) ? '0 : frame_cnt_q + 1'b1;
         end
         if (step) begin
            if (!dir) begin
               for (int j = 0; j < int'(COLS) - 1; j++) begin
                  fb_d[j] = fb_q[j+1];
               end
               fb_d[COLS-1] = enter_col;
            end else begin
               for (int j = 1; j < int'(COLS); j++) begin
                  fb_d[j] = fb_q[j-1];
               end
               fb_d[0] = enter_col;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q   <= '0;
         col_idx_q   <= '0;
         frame_cnt_q <= '0;
         fb_q        <= '{default: '0};
      end else begin
         div_cnt_q   <= div_cnt_d;
         col_idx_q   <= col_idx_d;
         frame_cnt_q <= frame_cnt_d;
         fb_q        <= fb_d;
      end
   end

   // Outputs are gated by rst so they drop the instant reset asserts, not at the next edge.
   always_comb begin
      col_sel     = '0;
      row         = '0;
      col_ready   = 1'b0;
      scroll_step = 1'b0;
      frame_start = 1'b0;
      if (rst) begin
         if (lit) begin
            col_sel = COLS'(1) << col_idx_q;
            row     = fb_q[col_idx_q];
         end
         col_ready   = step;
         scroll_step = step;
         frame_start = en && (div_cnt_q == '0) && (col_idx_q == '0);
      end
   end

endmodule

// File: tb/tb_matrix_scroller.sv
// Directed bench for matrix_scroller: COLS=5, ROWS=7, SCAN_DIV=4, BLANK=1, SCROLL_FRAMES=2.
module tb_matrix_scroller;

   logic       clk;
   logic       rst;
   logic       en;
   logic       scroll_en;
   logic       dir;
   logic [6:0] col_in;
   logic       col_valid;
   logic       col_ready;
   logic [4:0] col_sel;
   logic [6:0] row;
   logic       frame_start;
   logic       scroll_step;

   int total;
   int bad;

   logic [4:0] exp_sel;
   logic [6:0] exp_row;
   logic [6:0] exp_fb [5];

   matrix_scroller #(
      .COLS         (5),
      .ROWS         (7),
      .SCAN_DIV     (4),
      .BLANK        (1),
      .SCROLL_FRAMES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .scroll_en  (scroll_en),
      .dir        (dir),
      .col_in     (col_in),
      .col_valid  (col_valid),
      .col_ready  (col_ready),
      .col_sel    (col_sel),
      .row        (row),
      .frame_start(frame_start),
      .scroll_step(scroll_step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release with en=1 at cycle 0; cycles 1-3 lit on column 0, cycle 4 blank, cycle 5 column 1.
   task automatic test_reset();
      rst = 1'b0; en = 1'b1; scroll_en = 1'b1; dir = 1'b0;
      col_in = 7'h55; col_valid = 1'b1;
      tick(); tick(); tick();
      total++;
      if (col_sel !== 5'b0 || row !== 7'h0 || frame_start !== 1'b0 ||
          col_ready !== 1'b0 || scroll_step !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: sel=%b row=%h fs=%b rdy=%b step=%b, want all 0",
                  col_sel, row, frame_start, col_ready, scroll_step);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (frame_start !== 1'b1 || col_sel !== 5'b0) begin
         bad++;
         $display("FAIL reset_cyc0: fs=%b sel=%b, want 1 00000", frame_start, col_sel);
      end
      for (int c = 1; c <= 5; c++) begin
         tick();
         exp_sel = (c == 4) ? 5'b00000 : ((c == 5) ? 5'b00010 : 5'b00001);
         total++;
         if (col_sel !== exp_sel || row !== 7'h0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_cyc%0d: sel=%b row=%h fs=%b, want %b 00 0",
                     c, col_sel, row, frame_start, exp_sel);
         end
      end
   endtask

   // Starts at cycle 5; steps land at cycles 39 and 79.
   task automatic test_scroll_left();
      for (int n = 6; n <= 39; n++) begin
         tick();
         total++;
         if (col_ready !== (n == 39) || scroll_step !== (n == 39)) begin
            bad++;
            $display("FAIL left_step cyc=%0d: rdy=%b step=%b, want %b",
                     n, col_ready, scroll_step, (n == 39));
         end
      end
      exp_fb = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h55};
      for (int c = 0; c < 20; c++) begin
         tick();
         exp_sel = (c % 4 >= 1) ? 5'(1 << (c / 4)) : 5'b0;
         exp_row = (c % 4 >= 1) ? exp_fb[c / 4] : 7'h0;
         total++;
         if (col_sel !== exp_sel || row !== exp_row || scroll_step !== 1'b0) begin
            bad++;
            $display("FAIL left1 c=%0d: sel=%b row=%h step=%b, want %b %h 0",
                     c, col_sel, row, scroll_step, exp_sel, exp_row);
         end
      end
      for (int n = 60; n <= 79; n++) tick();
      total++;
      if (col_ready !== 1'b1 || scroll_step !== 1'b1) begin
         bad++;
         $display("FAIL left_step2: rdy=%b step=%b, want 1 1", col_ready, scroll_step);
      end
      exp_fb = '{7'h00, 7'h00, 7'h00, 7'h55, 7'h55};
      for (int c = 0; c < 20; c++) begin
         tick();
         exp_sel = (c % 4 >= 1) ? 5'(1 << (c / 4)) : 5'b0;
         exp_row = (c % 4 >= 1) ? exp_fb[c / 4] : 7'h0;
         total++;
         if (col_sel !== exp_sel || row !== exp_row) begin
            bad++;
            $display("FAIL left2 c=%0d: sel=%b row=%h, want %b %h",
                     c, col_sel, row, exp_sel, exp_row);
         end
      end
   endtask

   // Cycle 99 -> step at 119 with no valid column.
   task automatic test_starvation();
      col_valid = 1'b0;
      col_in    = 7'h2A;
      for (int n = 100; n <= 119; n++) tick();
      total++;
      if (col_ready !== 1'b1 || scroll_step !== 1'b1) begin
         bad++;
         $display("FAIL starve_step: rdy=%b step=%b, want 1 1", col_ready, scroll_step);
      end
      exp_fb = '{7'h00, 7'h00, 7'h55, 7'h55, 7'h00};
      for (int c = 0; c < 20; c++) begin
         tick();
         exp_sel = (c % 4 >= 1) ? 5'(1 << (c / 4)) : 5'b0;
         exp_row = (c % 4 >= 1) ? exp_fb[c / 4] : 7'h0;
         total++;
         if (col_sel !== exp_sel || row !== exp_row || col_ready !== 1'b0) begin
            bad++;
            $display("FAIL starve c=%0d: sel=%b row=%h rdy=%b, want %b %h 0",
                     c, col_sel, row, col_ready, exp_sel, exp_row);
         end
      end
   endtask

   // Cycle 139 -> step at 159, shifting right.
   task automatic test_scroll_right();
      dir = 1'b1; col_valid = 1'b1; col_in = 7'h7F;
      for (int n = 140; n <= 159; n++) tick();
      total++;
      if (col_ready !== 1'b1 || scroll_step !== 1'b1) begin
         bad++;
         $display("FAIL right_step: rdy=%b step=%b, want 1 1", col_ready, scroll_step);
      end
      exp_fb = '{7'h7F, 7'h00, 7'h00, 7'h55, 7'h55};
      for (int c = 0; c < 20; c++) begin
         tick();
         exp_sel = (c % 4 >= 1) ? 5'(1 << (c / 4)) : 5'b0;
         exp_row = (c % 4 >= 1) ? exp_fb[c / 4] : 7'h0;
         total++;
         if (col_sel !== exp_sel || row !== exp_row) begin
            bad++;
            $display("FAIL right c=%0d: sel=%b row=%h, want %b %h",
                     c, col_sel, row, exp_sel, exp_row);
         end
      end
   endtask

   // Cycle 179 -> pause at cycle 182 (div 2, col 0) for 10 cycles; step moves from 199 to 209.
   task automatic test_pause();
      tick(); tick(); tick();
      total++;
      if (col_sel !== 5'b00001 || row !== 7'h7F) begin
         bad++;
         $display("FAIL pause_pre: sel=%b row=%h, want 00001 7f", col_sel, row);
      end
      en = 1'b0;
      #1;
      total++;
      if (col_sel !== 5'b0 || row !== 7'h0) begin
         bad++;
         $display("FAIL pause_drop: sel=%b row=%h, want 00000 00", col_sel, row);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         total++;
         if (col_sel !== 5'b0 || row !== 7'h0 || col_ready !== 1'b0 || frame_start !== 1'b0 ||
             scroll_step !== 1'b0) begin
            bad++;
            $display("FAIL pause_hold k=%0d: sel=%b row=%h rdy=%b fs=%b step=%b, want all 0",
                     k, col_sel, row, col_ready, frame_start, scroll_step);
         end
      end
      en = 1'b1;
      #1;
      total++;
      if (col_sel !== 5'b00001 || row !== 7'h7F) begin
         bad++;
         $display("FAIL pause_resume: sel=%b row=%h, want 00001 7f", col_sel, row);
      end
      for (int n = 183; n <= 199; n++) begin
         tick();
         total++;
         if (col_ready !== (n == 199) || scroll_step !== (n == 199)) begin
            bad++;
            $display("FAIL pause_step nominal=%0d: rdy=%b step=%b, want %b",
                     n, col_ready, scroll_step, (n == 199));
         end
      end
   endtask

   // Buffer is now {7f,7f,00,00,55}; reset asynchronously mid-slot at nominal cycle 206.
   task automatic test_async_reset();
      for (int n = 200; n <= 206; n++) tick();
      total++;
      if (col_sel !== 5'b00010 || row !== 7'h7F) begin
         bad++;
         $display("FAIL arst_pre: sel=%b row=%h, want 00010 7f", col_sel, row);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (col_sel !== 5'b0 || row !== 7'h0 || frame_start !== 1'b0 ||
          col_ready !== 1'b0 || scroll_step !== 1'b0) begin
         bad++;
         $display("FAIL arst_now: sel=%b row=%h fs=%b rdy=%b step=%b, want all 0",
                  col_sel, row, frame_start, col_ready, scroll_step);
      end
      tick(); tick();
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (frame_start !== 1'b1 || col_sel !== 5'b0) begin
         bad++;
         $display("FAIL arst_cyc0: fs=%b sel=%b, want 1 00000", frame_start, col_sel);
      end
      for (int c = 1; c < 20; c++) begin
         tick();
         exp_sel = (c % 4 >= 1) ? 5'(1 << (c / 4)) : 5'b0;
         total++;
         if (col_sel !== exp_sel || row !== 7'h0) begin
            bad++;
            $display("FAIL arst_scan c=%0d: sel=%b row=%h, want %b 00", c, col_sel, row, exp_sel);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0; en = 1'b0; scroll_en = 1'b0; dir = 1'b0;
      col_in = '0; col_valid = 1'b0;
      test_reset();
      test_scroll_left();
      test_starvation();
      test_scroll_right();
      test_pause();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_scroller.md
# matrix_scroller

Parametrised scrolling driver for a column-multiplexed LED dot matrix: `COLS` columns by `ROWS` rows. It holds a `COLS`×`ROWS` frame buffer and scans it one column at a time, with a programmable blanking gap to suppress ghosting. Every `SCROLL_FRAMES` frames it shifts the picture one column left or right, taking the entering column from an upstream valid/ready source. It runs from one system clock with internal dividers and replaces the fixed 5×7, two-clock matrix driver.

## Interface
- `COLS`, 5, number of columns (≥2)
- `ROWS`, 7, number of rows (≥1)
- `SCAN_DIV`, 256, clk cycles per column slot (≥2)
- `BLANK`, 2, cycles at slot start with all outputs off (0 ≤ `BLANK` < `SCAN_DIV`)
- `SCROLL_FRAMES`, 32, full frames per scroll step (≥1)

Ports:
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `en` in 1: scan/scroll enable
- `scroll_en` in 1: allow scroll steps
- `dir` in 1: 0 = scroll left, 1 = scroll right
- `col_in` in `ROWS`: entering column data, bit r = row r
- `col_valid` in 1: `col_in` valid
- `col_ready` out 1: step cycle, column accepted if `col_valid`
- `col_sel` out `COLS`: one-hot column drive, active-high
- `row` out `ROWS`: row data for the selected column, active-high
- `frame_start` out 1: one-cycle pulse at each frame start
- `scroll_step` out 1: one-cycle pulse on each buffer shift

## Operation
- **State registers:**
  - `div_cnt` counts 0..`SCAN_DIV`-1.
  - `col_idx` counts 0..`COLS`-1.
  - `frame_cnt` counts 0..`SCROLL_FRAMES`-1.
  - `fb[0..COLS-1]` holds `ROWS` bits per column.
  - Counter widths are `$clog2` of their range, with a minimum of 1.
- **Reset (`rst`=0, async):**
  - All counters and `fb` go to 0.
  - All outputs are 0 immediately, without waiting for a clock edge.
- **Scan (en=1):**
  - `div_cnt` increments each cycle.
  - When `div_cnt` = `SCAN_DIV`-1 it wraps to 0 and `col_idx` advances, wrapping `COLS`-1→0.
- **Frame end:** `div_cnt`=`SCAN_DIV`-1 and `col_idx`=`COLS`-1. At frame end `frame_cnt` advances and wraps.
- **Display (combinational from registers):**
  - When en=1 and `div_cnt` ≥ `BLANK`: `col_sel` = 1<<`col_idx` and `row` = `fb[col_idx]`.
  - Otherwise both are 0.
- **Step cycle:** en & `scroll_en` & frame end & `frame_cnt`=`SCROLL_FRAMES`-1.
  - `col_ready`=1 only in the step cycle.
  - `scroll_step`=1 in the step cycle.
- **Buffer shift at the end of the step cycle:**
  - The entering value is `col_in` if `col_valid`; otherwise it is all-zero (a blank column is inserted and scrolling never stalls).
  - dir=0: `fb[j]`←`fb[j+1]` for j<`COLS`-1, and `fb[COLS-1]`←entering value.
  - dir=1: `fb[j]`←`fb[j-1]` for j>0, and `fb[0]`←entering value.
- **Handshake:** the upstream holds `col_valid`/`col_in` until it sees `col_ready`=1. A transfer occurs only when `col_valid` & `col_ready`.
- **`frame_start`:** = en & `div_cnt`=0 & `col_idx`=0.
- **en=0:**
  - All counters and `fb` hold.
  - `col_sel`, `row`, `col_ready`, `frame_start` and `scroll_step` are 0.
  - When en returns to 1, scanning resumes from the held position.
- **`scroll_en`=0:** `frame_cnt` keeps counting, but no step occurs and `col_ready` stays 0.
- **`dir` changes:** `dir` is sampled only in the step cycle. A change never tears a frame, because shifts happen only at a frame boundary.

## Timing
- Column slot: `SCAN_DIV` cycles, of which `SCAN_DIV`-`BLANK` are lit.
- Frame: `COLS`×`SCAN_DIV` cycles.
- Step period: `SCROLL_FRAMES`×frame cycles.
- First cycle after reset release with en=1: `frame_start`=1 and `col_sel`=0 when `BLANK`>0.
- A shifted column is visible from the cycle after the step cycle. That cycle is the first cycle of the next frame, and its slot is lit after `BLANK` cycles.
- Output latency from a state change: 0 cycles (combinational decode).

## Test plan
Bench parameters: `COLS`=5, `ROWS`=7, `SCAN_DIV`=4, `BLANK`=1, `SCROLL_FRAMES`=2. This gives 20-cycle frames and a step every 40 cycles.
1. **Reset:** hold `rst`=0 → all outputs are 0. Release with en=1 → cycle 0: `frame_start`=1, `col_sel`=0. Cycles 1–3: `col_sel`=5'b00001, `row`=0. Cycle 5: `col_sel`=5'b00010.
2. **Scroll left:** dir=0, `scroll_en`=1, `col_valid`=1, `col_in`=7'h55 → cycle 39: `col_ready`=1 and `scroll_step`=1. Next frame: during `col_sel`=5'b10000, `row`=7'h55; during the other columns, `row`=0. After the second step, columns 3 and 4 both show 7'h55.
3. **Starvation:** `col_valid`=0 at a step → `col_ready`=1, no transfer, `scroll_step`=1. Column 4 becomes 0 and the previous column 4 moves to column 3.
4. **Scroll right:** dir=1, `col_in`=7'h7F → after the step, `row`=7'h7F during `col_sel`=5'b00001, with the remaining columns shifted up.
5. **Pause:** drop en mid-slot at `div_cnt`=2 → `col_sel`/`row` are 0 in the same cycle and counters freeze. Re-assert after 10 cycles → display resumes at `div_cnt`=2 of the same column, and the step timing is delayed by exactly 10 cycles.
6. **Async reset mid-frame** with a loaded buffer: drive `rst`=0 between clock edges → outputs are 0 immediately. After release, all columns show `row`=0.
